// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C slave byte engine: FSM state encoding and
// the bus-level ACK/NACK values.
package i2c_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_DEV_ADDR  = 4'd1,
    S_ACK_DEV   = 4'd2,
    S_REG_PTR   = 4'd3,
    S_ACK_PTR   = 4'd4,
    S_WR_DATA   = 4'd5,
    S_ACK_WR    = 4'd6,
    S_RD_LOAD   = 4'd7,
    S_RD_DATA   = 4'd8,
    S_RD_ACK    = 4'd9,
    S_WAIT_STOP = 4'd10
  } I2cState;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_line_filter.sv
// One bus line: 2-flop synchroniser, FILTER_LEN consecutive-sample glitch
// filter and single-cycle edge pulses aligned with the filtered level.
module i2c_line_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [1:0] sync_q, sync_d;
  logic [2:0] cnt_q, cnt_d;
  logic       level_q, level_d;
  logic       rise_q, rise_d;
  logic       fall_q, fall_d;

  always_comb begin
    sync_d  = {sync_q[0], line_in};
    cnt_d   = 3'd0;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    // The level only moves after FILTER_LEN consecutive disagreeing samples.
    if (sync_q[1] != level_q) begin
      if (cnt_q == 3'(FILTER_LEN - 1)) begin
        level_d = sync_q[1];
        rise_d  = sync_q[1];
        fall_d  = ~sync_q[1];
      end else begin
        cnt_d = cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      cnt_q   <= 3'd0;
      level_q <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/i2c_slave_serial_if.sv
// Byte-level I2C slave: address match, auto-incrementing register pointer,
// write strobes towards the register bank and serialised read data.
module i2c_slave_serial_if
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR   = 7'h3C,
  parameter int         FILTER_LEN = 3,
  parameter int         SETUP_CYC  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] addr,
  output logic [7:0] dataIn,
  output logic       writeEn,
  input  logic [7:0] dataOut,
  output logic       busy
);

  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_sync_n;

  always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= rst_sync_d;
  end

  assign rst_sync_n = rst_sync_q[1];

  // Index 0 is SCL, index 1 is SDA.
  logic [1:0] line_raw, line_lvl, line_rise, line_fall;
  assign line_raw = {sda_in, scl_in};

  for (genvar gi = 0; gi < 2; gi++) begin : g_line
    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
      .clk    (clk),
      .rst_n  (rst_sync_n),
      .line_in(line_raw[gi]),
      .level  (line_lvl[gi]),
      .rise   (line_rise[gi]),
      .fall   (line_fall[gi])
    );
  end

  logic scl_lvl, scl_rise, scl_fall, sda_lvl, start_cond, stop_cond;
  assign scl_lvl    = line_lvl[0];
  assign scl_rise   = line_rise[0];
  assign scl_fall   = line_fall[0];
  assign sda_lvl    = line_lvl[1];
  assign start_cond = line_fall[1] & scl_lvl;
  assign stop_cond  = line_rise[1] & scl_lvl;

  I2cState    state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_in_q, data_in_d;
  logic       write_en_q, write_en_d;
  logic       busy_q, busy_d;
  logic       sda_oe_q, sda_oe_d;
  logic       oe_pend_q, oe_pend_d;
  logic [2:0] hold_cnt_q, hold_cnt_d;
  logic [1:0] wait_cnt_q, wait_cnt_d;
  logic       rw_q, rw_d;
  logic       ack_q, ack_d;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    addr_d     = addr_q;
    data_in_d  = data_in_q;
    write_en_d = 1'b0;
    busy_d     = busy_q;
    sda_oe_d   = sda_oe_q;
    oe_pend_d  = oe_pend_q;
    hold_cnt_d = hold_cnt_q;
    wait_cnt_d = wait_cnt_q;
    rw_d       = rw_q;
    ack_d      = ack_q;

    if (write_en_q) addr_d = addr_q + 8'd1;

    // SDA drive changes are queued at SCL fall and applied once the hold timer expires.
    if (hold_cnt_q != 3'd0) begin
      hold_cnt_d = hold_cnt_q - 3'd1;
      if (hold_cnt_q == 3'd1) sda_oe_d = oe_pend_q;
    end

    if (stop_cond) begin
      state_d    = S_IDLE;
      bit_cnt_d  = 4'd0;
      busy_d     = 1'b0;
      sda_oe_d   = 1'b0;
      oe_pend_d  = 1'b0;
      hold_cnt_d = 3'd0;
    end else if (start_cond) begin
      state_d    = S_DEV_ADDR;
      bit_cnt_d  = 4'd0;
      sda_oe_d   = 1'b0;
      oe_pend_d  = 1'b0;
      hold_cnt_d = 3'd0;
    end else if (scl_rise) begin
      case (state_q)
        S_DEV_ADDR, S_REG_PTR, S_WR_DATA: begin
          if (bit_cnt_q != 4'd8) begin
            shift_d   = {shift_q[6:0], sda_lvl};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        S_RD_DATA: bit_cnt_d = bit_cnt_q + 4'd1;
        S_RD_ACK:  ack_d = sda_lvl;
        default: ;
      endcase
    end else if (scl_fall) begin
      hold_cnt_d = 3'(SETUP_CYC);
      oe_pend_d  = 1'b0;
      case (state_q)
        S_DEV_ADDR: begin
          if (bit_cnt_q == 4'd8) begin
            bit_cnt_d = 4'd0;
            if (shift_q[7:1] == DEV_ADDR) begin
              state_d   = S_ACK_DEV;
              rw_d      = shift_q[0];
              busy_d    = 1'b1;
              oe_pend_d = ~I2C_ACK;
            end else begin
              state_d = S_WAIT_STOP;
            end
          end
        end
        S_ACK_DEV: begin
          state_d    = rw_q ? S_RD_LOAD : S_REG_PTR;
          wait_cnt_d = 2'd0;
        end
        S_REG_PTR: begin
          if (bit_cnt_q == 4'd8) begin
            bit_cnt_d = 4'd0;
            addr_d    = shift_q;
            state_d   = S_ACK_PTR;
            oe_pend_d = ~I2C_ACK;
          end
        end
        S_ACK_PTR, S_ACK_WR: state_d = S_WR_DATA;
        S_WR_DATA: begin
          if (bit_cnt_q == 4'd8) begin
            bit_cnt_d  = 4'd0;
            data_in_d  = shift_q;
            write_en_d = 1'b1;
            state_d    = S_ACK_WR;
            oe_pend_d  = ~I2C_ACK;
          end
        end
        S_RD_DATA: begin
          if (bit_cnt_q == 4'd8) begin
            bit_cnt_d = 4'd0;
            state_d   = S_RD_ACK;
          end else begin
            shift_d   = {shift_q[6:0], 1'b0};
            oe_pend_d = ~shift_q[6];
          end
        end
        S_RD_ACK: begin
          if (ack_q == I2C_ACK) begin
            addr_d     = addr_q + 8'd1;
            wait_cnt_d = 2'd0;
            state_d    = S_RD_LOAD;
          end else begin
            state_d = S_WAIT_STOP;
          end
        end
        default: ;
      endcase
    end

    // dataOut settles one clk after addr moves; also respect the SDA hold time.
    if (state_q == S_RD_LOAD && !stop_cond && !start_cond) begin
      if (wait_cnt_q != 2'd2) begin
        wait_cnt_d = wait_cnt_q + 2'd1;
      end else if (hold_cnt_q == 3'd0) begin
        shift_d   = dataOut;
        sda_oe_d  = ~dataOut[7];
        bit_cnt_d = 4'd0;
        state_d   = S_RD_DATA;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 8'h00;
      addr_q     <= 8'h00;
      data_in_q  <= 8'h00;
      write_en_q <= 1'b0;
      busy_q     <= 1'b0;
      sda_oe_q   <= 1'b0;
      oe_pend_q  <= 1'b0;
      hold_cnt_q <= 3'd0;
      wait_cnt_q <= 2'd0;
      rw_q       <= 1'b0;
      ack_q      <= I2C_NACK;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      addr_q     <= addr_d;
      data_in_q  <= data_in_d;
      write_en_q <= write_en_d;
      busy_q     <= busy_d;
      sda_oe_q   <= sda_oe_d;
      oe_pend_q  <= oe_pend_d;
      hold_cnt_q <= hold_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      rw_q       <= rw_d;
      ack_q      <= ack_d;
    end
  end

  assign sda_oe  = sda_oe_q;
  assign addr    = addr_q;
  assign dataIn  = data_in_q;
  assign writeEn = write_en_q;
  assign busy    = busy_q;

endmodule
